// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter.
// State encoding, clock rate and bit-period derivation.
package uart_tx_arbiter_pkg;

  localparam int CLK_FREQ = 100_000_000;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LAUNCH  = 2'd1;
  localparam logic [1:0] ST_SENDING = 2'd2;
  localparam logic [1:0] ST_GUARD   = 2'd3;

  function automatic int bit_period(input int baud);
    return CLK_FREQ / baud;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_uart_tx.sv
// Serial transmitter: start bit, LSB-first data, one stop bit.
// tx_busy_o rises the cycle after tx_start_i and falls after the stop bit.
module Uart_TX
  import uart_tx_arbiter_pkg::*;
#(
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_out_o,
  output logic                 tx_busy_o
);

  localparam int BP = bit_period(BAUD_RATE);
  localparam int CW = $clog2(DATA_BITS + 2);

  logic                 busy_q, busy_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS:0]   sh_q, sh_d;
  logic [CW-1:0]        bits_q, bits_d;
  logic [15:0]          baud_q, baud_d;

  // Bit timing and shift-out of the remaining data plus stop bit
  always_comb begin
    busy_d = busy_q;
    tx_d   = tx_q;
    sh_d   = sh_q;
    bits_d = bits_q;
    baud_d = baud_q;
    if (!busy_q) begin
      if (tx_start_i) begin
        busy_d = 1'b1;
        tx_d   = 1'b0;
        sh_d   = {1'b1, tx_data_i};
        bits_d = CW'(DATA_BITS + 1);
        baud_d = 16'(BP - 1);
      end
    end else if (baud_q != 16'd0) begin
      baud_d = baud_q - 16'd1;
    end else if (bits_q == '0) begin
      busy_d = 1'b0;
      tx_d   = 1'b1;
    end else begin
      tx_d   = sh_q[0];
      sh_d   = {1'b0, sh_q[DATA_BITS:1]};
      bits_d = bits_q - CW'(1);
      baud_d = 16'(BP - 1);
    end
  end

  // State registers; reset forces the line idle immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
      sh_q   <= '0;
      bits_q <= '0;
      baud_q <= '0;
    end else begin
      busy_q <= busy_d;
      tx_q   <= tx_d;
      sh_q   <= sh_d;
      bits_q <= bits_d;
      baud_q <= baud_d;
    end
  end

  assign tx_out_o  = tx_q;
  assign tx_busy_o = busy_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ clients.
// Each frame is followed by a one-bit guard so stop bits are never cut short.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int NUM_REQ   = 4,
  localparam int OWN_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         tx_out,
  output logic                         busy,
  output logic [OWN_W-1:0]             owner,
  output logic                         frame_done
);

  localparam int BIT_PERIOD = bit_period(BAUD_RATE);

  logic [1:0]           state_q, state_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [OWN_W-1:0]     last_q, last_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [15:0]          guard_q, guard_d;
  logic                 start_q, start_d;
  logic                 done_q, done_d;
  logic                 tx_busy;
  logic                 win_ok;
  logic [OWN_W-1:0]     win;

  // Round-robin search starting just past the previous grantee
  always_comb begin
    int idx;
    win_ok = 1'b0;
    win    = last_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_q) + i) % NUM_REQ;
      if (!win_ok && req[idx]) begin
        win_ok = 1'b1;
        win    = OWN_W'(idx);
      end
    end
  end

  // Grant, launch, wait for the frame, then hold the line for a guard bit
  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    owner_d = owner_q;
    last_d  = last_q;
    data_d  = data_q;
    guard_d = guard_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_ok) begin
          ack_d   = NUM_REQ'(1) << win;
          start_d = 1'b1;
          data_d  = req_data[win*DATA_BITS +: DATA_BITS];
          owner_d = win;
          last_d  = win;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (tx_busy) state_d = ST_SENDING;
      end
      ST_SENDING: begin
        if (!tx_busy) begin
          guard_d = 16'(BIT_PERIOD - 1);
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_q == 16'd0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state; reset re-arms the search at index 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= '0;
      owner_q <= '0;
      last_q  <= OWN_W'(NUM_REQ - 1);
      data_q  <= '0;
      guard_q <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      data_q  <= data_d;
      guard_q <= guard_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  Uart_TX #(
    .BAUD_RATE (BAUD_RATE),
    .DATA_BITS (DATA_BITS)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .tx_start_i (start_q),
    .tx_data_i  (data_q),
    .tx_out_o   (tx_out),
    .tx_busy_o  (tx_busy)
  );

  assign ack        = ack_q;
  assign busy       = (state_q != ST_IDLE);
  assign owner      = owner_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter at 1 Mbaud (100 clocks per bit).
// Stimulus queues expected acks and bytes; monitors pop and compare.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DB = 8;
  localparam int BR = 1_000_000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*DB-1:0] req_data;
  logic [NR-1:0] ack;
  logic          tx_out;
  logic          busy;
  logic [1:0]    owner;
  logic          frame_done;

  int         checks = 0;
  int         errors = 0;
  int         fd_cnt = 0;
  int         exp_ack_q[$];
  logic [7:0] exp_rx_q[$];

  uart_tx_arbiter #(
    .BAUD_RATE (BR),
    .DATA_BITS (DB),
    .NUM_REQ   (NR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .tx_out     (tx_out),
    .busy       (busy),
    .owner      (owner),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Ack monitor: compare each grant against the queued expectation
  initial begin
    logic [NR-1:0] prev;
    int e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst && ack != '0) begin
        if (exp_ack_q.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 0);
        end else begin
          e = exp_ack_q.pop_front();
          chk("ack_vec", 32'(ack), 32'(1) << e);
          chk("ack_owner", 32'(owner), e);
        end
        chk("ack_one_cycle", 32'(ack & prev), 0);
        chk("ack_with_done", 32'(frame_done), 0);
      end
      if (frame_done) fd_cnt++;
      prev = ack;
    end
  end

  // RX model: mid-bit sampling, stop-bit and inter-frame gap checks
  initial begin
    int t;
    int hi;
    bit act;
    bit prev_ok;
    logic [7:0] b;
    t = 0; hi = 0; act = 0; prev_ok = 0; b = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 0;
        prev_ok = 0;
        hi = 0;
      end else begin
        if (!act) begin
          if (tx_out === 1'b0) begin
            if (prev_ok) chk("gap_ge_100", 32'(hi >= 100), 1);
            act = 1;
            t = 0;
          end
        end else begin
          t++;
          if (t == 50) begin
            chk("rx_start", 32'(tx_out), 0);
          end else if (t > 50 && t < 950 && (t - 50) % 100 == 0) begin
            b[(t - 50) / 100 - 1] = tx_out;
          end else if (t == 950) begin
            chk("rx_stop", 32'(tx_out), 1);
            if (exp_rx_q.size() == 0)
              chk("unexpected_rx", 32'(exp_rx_q.size()), 1);
            else
              chk("rx_byte", 32'(b), 32'(exp_rx_q.pop_front()));
            act = 0;
            prev_ok = 1;
          end
        end
        hi = (tx_out === 1'b1) ? hi + 1 : 0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack[i] !== 1'b1 && n < 3000);
    if (ack[i] !== 1'b1) chk("ack_timeout", 32'(ack), 32'(1) << i);
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 3000);
    if (frame_done !== 1'b1) chk("done_timeout", 32'(frame_done), 1);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int f0;
    int n;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_out), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_done", 32'(frame_done), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_tx", 32'(tx_out), 1);

    // single request from index 2
    req_data[23:16] = 8'hA5;
    exp_ack_q.push_back(2);
    exp_rx_q.push_back(8'hA5);
    f0 = fd_cnt;
    req = 4'b0100;
    wait_ack(2);
    req = '0;
    wait_fd();
    repeat (5) @(negedge clk);
    chk("t1_done_once", fd_cnt - f0, 1);
    chk("t1_busy", 32'(busy), 0);
    req_data[23:16] = 8'h33;

    // all held high: rotation 0,1,2,3,0
    pulse_rst();
    foreach (exp_ack_q[i]) exp_ack_q.delete();
    for (int i = 0; i < 5; i++) begin
      exp_ack_q.push_back(i % NR);
      exp_rx_q.push_back(8'(8'h11 * ((i % NR) + 1)));
    end
    req = 4'b1111;
    repeat (5) wait_fd();
    req = '0;
    repeat (5) @(negedge clk);
    chk("t2_acks_left", exp_ack_q.size(), 0);
    chk("t2_rx_left", exp_rx_q.size(), 0);

    // grant 3, then 1001 must wrap to 0
    exp_ack_q.push_back(3);
    exp_rx_q.push_back(8'h44);
    req = 4'b1000;
    wait_ack(3);
    req = '0;
    wait_fd();
    exp_ack_q.push_back(0);
    exp_rx_q.push_back(8'h11);
    req = 4'b1001;
    wait_ack(0);
    chk("t3_owner_wrap", 32'(owner), 0);
    req = '0;
    wait_fd();

    // reset in the middle of data bit 4
    exp_ack_q.push_back(0);
    req = 4'b0001;
    wait_ack(0);
    req = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_out !== 1'b0 && n < 100);
    chk("t4_start_seen", 32'(tx_out), 0);
    repeat (550) @(negedge clk);
    f0 = fd_cnt;
    rst = 1'b1;
    #1;
    chk("t4_async_tx", 32'(tx_out), 1);
    chk("t4_async_busy", 32'(busy), 0);
    repeat (2) begin
      @(negedge clk);
      chk("t4_rst_tx", 32'(tx_out), 1);
      chk("t4_rst_busy", 32'(busy), 0);
      chk("t4_rst_ack", 32'(ack), 0);
    end
    @(negedge clk);
    exp_ack_q.push_back(1);
    exp_rx_q.push_back(8'h22);
    req = 4'b0010;
    rst = 1'b0;
    wait_ack(1);
    chk("t4_no_done", fd_cnt - f0, 0);
    req = '0;
    wait_fd();

    // stray one-cycle req[1] during owner 0's frame
    exp_ack_q.push_back(0);
    exp_rx_q.push_back(8'h11);
    req = 4'b0001;
    wait_ack(0);
    req = '0;
    repeat (300) @(negedge clk);
    chk("t5_busy_mid", 32'(busy), 1);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    wait_fd();
    repeat (20) @(negedge clk);
    chk("t5_busy_end", 32'(busy), 0);
    chk("t5_tx_idle", 32'(tx_out), 1);
    chk("end_acks_left", exp_ack_q.size(), 0);
    chk("end_rx_left", exp_rx_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
